// File: rtl/line_memory_pkg.sv
// Shared defaults and FSM encoding for the line-granular main-memory model.
package line_memory_pkg;
  localparam int LINE_BITS_DFLT   = 256;
  localparam int DEPTH_DFLT       = 512;
  localparam int MEM_LATENCY_DFLT = 10;
  localparam int CNT_W            = 8;
  localparam int OFFSET_BITS      = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/line_memory.sv
// Whole-line memory model: request accepted in IDLE, one-cycle ack_o MEM_LATENCY edges later.
// No backpressure; the requester holds enable_i and request fields until ack_o.
module line_memory
  import line_memory_pkg::*;
#(
  parameter int LINE_BITS   = LINE_BITS_DFLT,
  parameter int DEPTH       = DEPTH_DFLT,
  parameter int MEM_LATENCY = MEM_LATENCY_DFLT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  output logic                 ack_o,
  output logic [LINE_BITS-1:0] data_o
);
  localparam int              IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  if (MEM_LATENCY < 2 || MEM_LATENCY > 255) begin : g_bad_latency
    $error("line_memory: MEM_LATENCY must be in 2..255");
  end

  logic [LINE_BITS-1:0] memory [0:DEPTH-1];

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_write;
  logic [LINE_BITS-1:0] r_wdata;
  logic                 r_ack;
  logic [LINE_BITS-1:0] r_rdata;
  logic                 w_accept;
  logic                 w_done;
  logic                 w_mem_wr;
  logic                 w_mem_rd;
  logic                 w_unused_addr;

  assign w_unused_addr = ^{addr_i[31:OFFSET_BITS+IDX_W], addr_i[OFFSET_BITS-1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable_i) w_state_nxt = BUSY;
      BUSY:    if (r_cnt == LAST_CNT) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == IDLE) && enable_i;
    w_done   = (r_state == BUSY) && (r_cnt == LAST_CNT);
    w_mem_wr = w_done && r_write;
    w_mem_rd = w_done && !r_write;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_done;
      if (w_accept)              r_cnt <= '0;
      else if (r_state == BUSY)  r_cnt <= r_cnt + 1'b1;
      if (w_mem_rd)              r_rdata <= memory[r_idx];
    end
  end

  // Request fields are latched once; later changes on the inputs are ignored.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_idx   <= addr_i[OFFSET_BITS +: IDX_W];
      r_write <= write_i;
      r_wdata <= data_i;
    end
  end

  // The array is never reset; reset only blocks a pending commit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_mem_wr) memory[r_idx] <= r_wdata;
  end

  assign ack_o  = r_ack;
  assign data_o = r_rdata;
endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: latency, data paths, aliasing, back-to-back and reset abort.
module tb_line_memory;
  import line_memory_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] PAT_A5  = {32{8'hA5}};
  localparam logic [255:0] PAT_DB  = {8{32'hDEADBEEF}};
  localparam logic [255:0] PAT_JNK = {16{16'h0F0F}};
  localparam logic [255:0] PAT_M1  = {4{64'h1111_2222_3333_4444}};
  localparam logic [255:0] PAT_P2  = {8{32'h0000_0202}};
  localparam logic [255:0] PAT_P7  = {8{32'h7777_0007}};
  localparam logic [255:0] PAT_P5O = {8{32'h5555_AAAA}};
  localparam logic [255:0] PAT_P5N = {8{32'hFFFF_0000}};

  line_memory #(.LINE_BITS(256), .DEPTH(512), .MEM_LATENCY(10)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .enable_i(enable_i),
    .write_i (write_i),
    .ack_o   (ack_o),
    .data_o  (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until ack_o is seen; lat is the number of edges waited, -1 on timeout.
  task automatic wait_ack(output int lat);
    int l;
    l = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ack_o) begin
        l = c;
        break;
      end
    end
    lat = l;
  endtask

  task automatic run_txn(input logic we, input logic [31:0] a, input logic [255:0] d,
                         output int lat);
    int l;
    write_i  = we;
    addr_i   = a;
    data_i   = d;
    enable_i = 1'b1;
    tick();
    wait_ack(l);
    enable_i = 1'b0;
    lat = l;
  endtask

  initial begin
    int lat;
    int acks;

    rst_i    = 1'b1;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = 32'h0;
    data_i   = '0;
    dut.memory[0] = 256'h5;
    dut.memory[1] = PAT_M1;
    dut.memory[5] = PAT_P5O;
    dut.memory[7] = PAT_P7;

    tick();
    tick();
    chk("rst_ack", 256'(ack_o), 256'(0));
    chk("rst_data", data_o, 256'h0);
    chk("rst_mem0_kept", dut.memory[0], 256'h5);
    chk("rst_state", 256'(dut.r_state), 256'(IDLE));
    rst_i = 1'b0;
    tick();

    // Read of a preloaded line.
    run_txn(1'b0, 32'h0000_0000, '0, lat);
    chk("rd0_latency", 256'(lat), 256'(10));
    chk("rd0_data", data_o, 256'h5);
    tick();
    chk("rd0_ack_one_cycle", 256'(ack_o), 256'(0));
    chk("rd0_data_hold", data_o, 256'h5);

    // Write then read index 33.
    run_txn(1'b1, 32'h0000_0420, PAT_A5, lat);
    chk("wr33_latency", 256'(lat), 256'(10));
    chk("wr33_mem", dut.memory[33], PAT_A5);
    chk("wr33_data_o_unchanged", data_o, 256'h5);
    tick();
    run_txn(1'b0, 32'h0000_0420, '0, lat);
    chk("rd33_latency", 256'(lat), 256'(10));
    chk("rd33_data", data_o, PAT_A5);
    tick();

    // Aliased write; inputs disturbed mid-flight must be ignored.
    write_i  = 1'b1;
    addr_i   = 32'h0000_401F;
    data_i   = PAT_DB;
    enable_i = 1'b1;
    tick();
    tick();
    tick();
    tick();
    write_i = 1'b0;
    addr_i  = 32'h0000_0020;
    data_i  = PAT_JNK;
    wait_ack(lat);
    enable_i = 1'b0;
    chk("alias_wr_lat_rem", 256'(lat), 256'(7));
    chk("alias_mem0", dut.memory[0], PAT_DB);
    chk("alias_mem1_untouched", dut.memory[1], PAT_M1);
    tick();
    run_txn(1'b0, 32'h0000_0000, '0, lat);
    chk("alias_rd_latency", 256'(lat), 256'(10));
    chk("alias_rd_data", data_o, PAT_DB);
    tick();

    // Write-back followed immediately by refill, enable held through the ack.
    write_i  = 1'b1;
    addr_i   = 32'h0000_0040;
    data_i   = PAT_P2;
    enable_i = 1'b1;
    tick();
    wait_ack(lat);
    chk("b2b_wr_latency", 256'(lat), 256'(10));
    chk("b2b_mem2", dut.memory[2], PAT_P2);
    write_i = 1'b0;
    addr_i  = 32'h0000_00E0;
    tick();
    wait_ack(lat);
    enable_i = 1'b0;
    chk("b2b_rd_latency", 256'(lat), 256'(10));
    chk("b2b_rd_data", data_o, PAT_P7);
    tick();

    // Reset four cycles into a write aborts it.
    write_i  = 1'b1;
    addr_i   = 32'h0000_00A0;
    data_i   = PAT_P5N;
    enable_i = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    chk("abort_state", 256'(dut.r_state), 256'(IDLE));
    rst_i    = 1'b0;
    enable_i = 1'b0;
    acks     = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (ack_o) acks++;
    end
    chk("abort_no_ack", 256'(acks), 256'(0));
    chk("abort_mem5", dut.memory[5], PAT_P5O);
    chk("abort_data_o_cleared", data_o, 256'h0);
    chk("abort_mem33_kept", dut.memory[33], PAT_A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
